// File: rtl/wb_arbiter_if.sv
// Bus bundle between N Wishbone masters, the arbiter and the single downstream slave.
// i_/o_ prefixes are from the arbiter's point of view; master modport = environment side.
interface wb_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [NUM_MASTERS-1:0]        i_m_cyc;
    logic [NUM_MASTERS*SEL_W-1:0]  i_m_stb;
    logic [NUM_MASTERS-1:0]        i_m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] i_m_dat;
    logic [NUM_MASTERS-1:0]        o_m_ack;
    logic [NUM_MASTERS-1:0]        o_m_err;
    logic [DATA_W-1:0]             o_m_dat;
    logic [NUM_MASTERS-1:0]        o_grant;

    logic                          o_wb_cyc;
    logic [SEL_W-1:0]              o_wb_stb;
    logic                          o_wb_we;
    logic [ADDR_W-1:0]             o_wb_addr;
    logic [DATA_W-1:0]             o_wb_dat;
    logic [DATA_W-1:0]             i_wb_dat;
    logic                          i_wb_ack;
    logic                          i_wb_err;

    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_dat,
        output i_wb_dat, i_wb_ack, i_wb_err,
        input  o_m_ack, o_m_err, o_m_dat, o_grant,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat
    );

    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_dat,
        input  i_wb_dat, i_wb_ack, i_wb_err,
        output o_m_ack, o_m_err, o_m_dat, o_grant,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat
    );
endinterface

// File: rtl/wb_arbiter.sv
// N-to-1 Wishbone arbiter with locked, registered grants (round-robin or fixed priority).
// Latency: grant one cycle after request on an idle bus; one idle cycle between owners.
// Backpressure: losers simply wait with cyc held; WB_ARB_TIMEOUT_EN adds a hung-slave watchdog.
module wb_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         i_clk,
    input  logic         i_reset,
    wb_arbiter_if.slave  bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]          r_gidx,  w_gidx_nxt;
    logic [IW-1:0]          r_last,  w_last_nxt;

    logic                   w_busy;
    logic                   w_cur_cyc;
    logic                   w_timeout;
    logic                   w_win_vld;
    logic [IW-1:0]          w_win_idx;
    logic [SEL_W-1:0]       w_sel_stb;
    logic                   w_sel_we;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_dat;

    assign w_busy = (r_state == ST_GRANTED);

    // Winner selection; only consulted while idle.
    always_comb begin
        int w_pos;
        w_win_vld = |bus.i_m_cyc;
        w_win_idx = '0;
        w_pos     = 0;
        if (PRIORITY_MODE == 1) begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (bus.i_m_cyc[k]) w_win_idx = IW'(k);
            end
        end else begin
            // Scan downward so the nearest requester after r_last is assigned last.
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                w_pos = int'(r_last) + k;
                if (w_pos >= NUM_MASTERS) w_pos = w_pos - NUM_MASTERS;
                if (bus.i_m_cyc[IW'(w_pos)]) w_win_idx = IW'(w_pos);
            end
        end
    end

    always_comb begin
        w_cur_cyc  = 1'b0;
        w_sel_stb  = '0;
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_dat  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_gidx == IW'(k)) begin
                w_cur_cyc  = bus.i_m_cyc[k];
                w_sel_stb  = bus.i_m_stb[k*SEL_W +: SEL_W];
                w_sel_we   = bus.i_m_we[k];
                w_sel_addr = bus.i_m_addr[k*ADDR_W +: ADDR_W];
                w_sel_dat  = bus.i_m_dat[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Held at zero while idle, so every new grant starts from a cleared count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (!w_busy || bus.i_wb_ack || bus.i_wb_err) begin
            r_cnt <= '0;
        end else if ((|w_sel_stb) && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_GRANTED;
                    w_grant_nxt = NUM_MASTERS'(1) << w_win_idx;
                    w_gidx_nxt  = w_win_idx;
                end
            end
            ST_GRANTED: begin
                if (!w_cur_cyc || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_gidx;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Everything below depends on registered state, so reset clears it without a clock edge.
    always_comb begin
        bus.o_grant   = r_grant;
        bus.o_m_dat   = bus.i_wb_dat;
        bus.o_m_ack   = '0;
        bus.o_m_err   = '0;
        bus.o_wb_cyc  = 1'b0;
        bus.o_wb_stb  = '0;
        bus.o_wb_we   = 1'b0;
        bus.o_wb_addr = '0;
        bus.o_wb_dat  = '0;
        if (w_busy) begin
            bus.o_wb_cyc  = w_cur_cyc && !w_timeout;
            bus.o_wb_stb  = w_timeout ? '0 : w_sel_stb;
            bus.o_wb_we   = w_sel_we;
            bus.o_wb_addr = w_sel_addr;
            bus.o_wb_dat  = w_sel_dat;
            bus.o_m_ack   = w_timeout ? '0 : ({NUM_MASTERS{bus.i_wb_ack}} & r_grant);
            bus.o_m_err   = {NUM_MASTERS{bus.i_wb_err | w_timeout}} & r_grant;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter sharing clock and reset.
// Timeout vectors apply only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;
    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic i_clk = 1'b0;
    logic i_reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 i_clk = ~i_clk;

    wb_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    wb_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    wb_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4))
        u_rr (.i_clk(i_clk), .i_reset(i_reset), .bus(bus_rr));
    wb_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(4))
        u_fp (.i_clk(i_clk), .i_reset(i_reset), .bus(bus_fp));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        i_reset          = 1'b0;
        bus_rr.i_m_cyc   = 3'b111;
        bus_rr.i_m_stb   = {N{4'hF}};
        bus_rr.i_m_we    = 3'b010;
        bus_rr.i_m_addr  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        bus_rr.i_m_dat   = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        bus_rr.i_wb_dat  = '0;
        bus_rr.i_wb_ack  = 1'b1;
        bus_rr.i_wb_err  = 1'b1;
        bus_fp.i_m_cyc   = 3'b000;
        bus_fp.i_m_stb   = {N{4'hF}};
        bus_fp.i_m_we    = 3'b000;
        bus_fp.i_m_addr  = {32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        bus_fp.i_m_dat   = '0;
        bus_fp.i_wb_dat  = '0;
        bus_fp.i_wb_ack  = 1'b0;
        bus_fp.i_wb_err  = 1'b0;

        // Held in reset with every master requesting and the slave responding.
        repeat (3) tick();
        settle();
        chk("rst_grant", bus_rr.o_grant, 3'b000);
        chk("rst_wb_cyc", bus_rr.o_wb_cyc, 1'b0);
        chk("rst_wb_stb", bus_rr.o_wb_stb, 4'h0);
        chk("rst_wb_addr", bus_rr.o_wb_addr, 32'h0);
        chk("rst_m_ack", bus_rr.o_m_ack, 3'b000);
        chk("rst_m_err", bus_rr.o_m_err, 3'b000);

        bus_rr.i_wb_ack = 1'b0;
        bus_rr.i_wb_err = 1'b0;
        i_reset = 1'b1;
        tick();
        chk("rel_grant", bus_rr.o_grant, 3'b001);
        chk("rel_wb_cyc", bus_rr.o_wb_cyc, 1'b1);
        chk("rel_wb_addr", bus_rr.o_wb_addr, 32'hA000_0000);

        // Master 0: ack arrives in the same cycle it drops cyc.
        bus_rr.i_wb_ack = 1'b1;
        bus_rr.i_m_cyc  = 3'b110;
        settle();
        chk("m0_ack", bus_rr.o_m_ack, 3'b001);
        chk("m0_drop_wb_cyc", bus_rr.o_wb_cyc, 1'b0);
        tick();
        chk("idle1_grant", bus_rr.o_grant, 3'b000);
        chk("idle1_ack_ignored", bus_rr.o_m_ack, 3'b000);
        bus_rr.i_wb_ack = 1'b0;
        bus_rr.i_m_cyc  = 3'b111;

        // Master 1: response routing.
        tick();
        chk("rr_grant_m1", bus_rr.o_grant, 3'b010);
        chk("m1_wb_addr", bus_rr.o_wb_addr, 32'hA000_0001);
        chk("m1_wb_we", bus_rr.o_wb_we, 1'b1);
        chk("m1_wb_dat", bus_rr.o_wb_dat, 32'hD000_0001);
        bus_rr.i_wb_dat = 32'hDEAD_BEEF;
        bus_rr.i_wb_ack = 1'b1;
        bus_rr.i_m_cyc  = 3'b101;
        settle();
        chk("m1_ack", bus_rr.o_m_ack, 3'b010);
        chk("m1_rdat", bus_rr.o_m_dat, 32'hDEAD_BEEF);
        chk("m1_err", bus_rr.o_m_err, 3'b000);
        tick();
        chk("idle2_grant", bus_rr.o_grant, 3'b000);
        bus_rr.i_wb_ack = 1'b0;
        bus_rr.i_m_cyc  = 3'b111;

        // Master 2: error response.
        tick();
        chk("rr_grant_m2", bus_rr.o_grant, 3'b100);
        bus_rr.i_wb_err = 1'b1;
        bus_rr.i_m_cyc  = 3'b011;
        settle();
        chk("m2_err", bus_rr.o_m_err, 3'b100);
        chk("m2_no_ack", bus_rr.o_m_ack, 3'b000);
        tick();
        bus_rr.i_wb_err = 1'b0;
        bus_rr.i_m_cyc  = 3'b111;

        // Wrap back to master 0, then several beats inside one locked cycle.
        tick();
        chk("rr_grant_wrap_m0", bus_rr.o_grant, 3'b001);
        bus_rr.i_wb_ack = 1'b1;
        settle();
        chk("beat1_ack", bus_rr.o_m_ack, 3'b001);
        tick();
        chk("beat1_locked", bus_rr.o_grant, 3'b001);
        bus_rr.i_wb_ack = 1'b0;
        tick();
        chk("beat2_locked", bus_rr.o_grant, 3'b001);

        // Reset while master 2 owns the bus.
        bus_rr.i_m_cyc = 3'b100;
        tick();
        tick();
        chk("m2_only_grant", bus_rr.o_grant, 3'b100);
        chk("m2_only_wb_cyc", bus_rr.o_wb_cyc, 1'b1);
        bus_rr.i_wb_ack = 1'b1;
        #3 i_reset = 1'b0;
        #1;
        chk("midrst_grant", bus_rr.o_grant, 3'b000);
        chk("midrst_wb_cyc", bus_rr.o_wb_cyc, 1'b0);
        chk("midrst_m_ack", bus_rr.o_m_ack, 3'b000);
        bus_rr.i_wb_ack = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        chk("postrst_grant", bus_rr.o_grant, 3'b100);
        bus_rr.i_m_cyc = 3'b000;
        tick();
        chk("postrst_idle", bus_rr.o_grant, 3'b000);

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never answers: error pulse after four strobe cycles.
        bus_rr.i_m_cyc = 3'b011;
        tick();
        chk("to_grant_m0", bus_rr.o_grant, 3'b001);
        repeat (3) tick();
        settle();
        chk("to_no_err_yet", bus_rr.o_m_err, 3'b000);
        tick();
        settle();
        chk("to_err_pulse", bus_rr.o_m_err, 3'b001);
        chk("to_wb_cyc_low", bus_rr.o_wb_cyc, 1'b0);
        chk("to_wb_stb_low", bus_rr.o_wb_stb, 4'h0);
        tick();
        chk("to_idle", bus_rr.o_grant, 3'b000);
        chk("to_err_gone", bus_rr.o_m_err, 3'b000);
        tick();
        chk("to_next_m1", bus_rr.o_grant, 3'b010);
        bus_rr.i_m_cyc = 3'b000;
        tick();
`endif

        // Fixed priority: 1 and 2 request, 0 joins during 1's cycle.
        bus_fp.i_m_cyc = 3'b110;
        tick();
        chk("fp_grant_m1", bus_fp.o_grant, 3'b010);
        chk("fp_wb_addr", bus_fp.o_wb_addr, 32'hB000_0001);
        tick();
        chk("fp_m1_locked", bus_fp.o_grant, 3'b010);
        bus_fp.i_m_cyc = 3'b111;
        tick();
        chk("fp_m1_still", bus_fp.o_grant, 3'b010);
        bus_fp.i_m_cyc = 3'b101;
        tick();
        chk("fp_idle", bus_fp.o_grant, 3'b000);
        tick();
        chk("fp_grant_m0", bus_fp.o_grant, 3'b001);
        bus_fp.i_m_cyc = 3'b100;
        tick();
        tick();
        chk("fp_grant_m2", bus_fp.o_grant, 3'b100);
        bus_fp.i_m_cyc = 3'b000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
